uop_credit_despatcher: RTL and testbench



---
 rtl/uop_credit_despatcher_pkg.sv | 9 +
 rtl/uop_credit_despatcher.sv | 199 +++++++++++++++++++
 tb/tb_uop_credit_despatcher.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uop_credit_despatcher_pkg.sv
// rtl/uop_credit_despatcher_pkg.sv - micro-op type shared by the despatcher and its users
package uop_credit_despatcher_pkg;
    localparam int EU_W = 3;

    typedef struct packed {
        logic [EU_W-1:0] exec_unit;
        logic [15:0]     payload;
    } micro_op_t;
endpackage

// File: rtl/uop_credit_despatcher.sv
// rtl/uop_credit_despatcher.sv - in-order credit-based uop despatcher with buffer bypass
// Optional perf counters built when DESP_PERF_CNT_EN is defined; otherwise tied to 0.
module uop_credit_despatcher
    import uop_credit_despatcher_pkg::*;
#(
    parameter int IN_WIDTH       = 3,
    parameter int OUT_WIDTH      = 2,
    parameter int BUFFER_LEN     = 8,
    parameter int NUM_SCHEDULERS = 4,
    parameter int SCHED_CREDITS  = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_flush,
    input  logic [IN_WIDTH-1:0]               i_desp_inp_p,
    input  micro_op_t                         i_desp_inp [IN_WIDTH],
    output logic [$clog2(BUFFER_LEN+1)-1:0]   o_desp_src_num_avail,
    output logic [NUM_SCHEDULERS-1:0]         o_sched_uop_p,
    output micro_op_t                         o_sched_inp [NUM_SCHEDULERS],
    input  logic [NUM_SCHEDULERS-1:0]         i_sched_credit_ret,
    output logic                              o_credit_err,
    output logic [31:0]                       o_perf_desp_cnt,
    output logic [31:0]                       o_perf_stall_cnt
);
    localparam int PTR_W = $clog2(BUFFER_LEN);
    localparam int OCC_W = $clog2(BUFFER_LEN + 1);
    localparam int CRD_W = $clog2(SCHED_CREDITS + 1);

    micro_op_t            buf_mem [BUFFER_LEN];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [OCC_W-1:0]     occ;
    logic [CRD_W-1:0]     credit [NUM_SCHEDULERS];
    logic                 credit_err;

    logic [IN_WIDTH-1:0]  in_valid;
    logic [OCC_W-1:0]     n_in;
    logic [OCC_W-1:0]     n_desp;
    logic [OCC_W-1:0]     pop_cnt;
    logic [OCC_W-1:0]     byp_cnt;
    logic [OCC_W-1:0]     push_cnt;
    micro_op_t            win [OUT_WIDTH];
    logic [OUT_WIDTH-1:0] win_v;
    micro_op_t            push_uop [IN_WIDTH];

    // Only the contiguous run of present bits from bit 0 counts.
    always_comb begin : in_mask
        logic run;
        run  = 1'b1;
        n_in = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            run         = run & i_desp_inp_p[i];
            in_valid[i] = run;
            n_in        = n_in + OCC_W'(run);
        end
    end

    // Window: buffered uops first, then the incoming uops fill the remaining slots.
    always_comb begin : window
        for (int k = 0; k < OUT_WIDTH; k++) begin
            win[k]   = '0;
            win_v[k] = 1'b0;
            if (OCC_W'(k) < occ) begin
                win[k]   = buf_mem[rd_ptr + PTR_W'(k)];
                win_v[k] = 1'b1;
            end else begin
                for (int i = 0; i < IN_WIDTH; i++) begin
                    if (OCC_W'(i) == OCC_W'(k) - occ) begin
                        win[k]   = i_desp_inp[i];
                        win_v[k] = in_valid[i];
                    end
                end
            end
        end
    end

    // In-order walk: the first slot that cannot go blocks every younger slot.
    always_comb begin : walk
        logic                      stop;
        logic                      ok;
        logic [NUM_SCHEDULERS-1:0] used;
        stop          = 1'b0;
        ok            = 1'b0;
        used          = '0;
        n_desp        = '0;
        o_sched_uop_p = '0;
        for (int s = 0; s < NUM_SCHEDULERS; s++) begin
            o_sched_inp[s] = '0;
        end
        for (int k = 0; k < OUT_WIDTH; k++) begin
            ok = 1'b0;
            for (int s = 0; s < NUM_SCHEDULERS; s++) begin
                if (win[k].exec_unit == EU_W'(s) && credit[s] != '0 && !used[s]) begin
                    ok = 1'b1;
                end
            end
            ok = ok & win_v[k] & ~stop & ~i_flush & ~i_rst;
            if (ok) begin
                n_desp = n_desp + OCC_W'(1);
                for (int s = 0; s < NUM_SCHEDULERS; s++) begin
                    if (win[k].exec_unit == EU_W'(s)) begin
                        used[s]          = 1'b1;
                        o_sched_uop_p[s] = 1'b1;
                        o_sched_inp[s]   = win[k];
                    end
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    // Despatched slots come from the buffer first; the rest were bypassed inputs.
    assign pop_cnt  = (n_desp < occ) ? n_desp : occ;
    assign byp_cnt  = n_desp - pop_cnt;
    assign push_cnt = n_in - byp_cnt;

    always_comb begin : push_sel
        for (int j = 0; j < IN_WIDTH; j++) begin
            push_uop[j] = '0;
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (OCC_W'(i) == byp_cnt + OCC_W'(j)) begin
                    push_uop[j] = i_desp_inp[i];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush) begin
            for (int j = 0; j < IN_WIDTH; j++) begin
                if (OCC_W'(j) < push_cnt) begin
                    buf_mem[wr_ptr + PTR_W'(j)] <= push_uop[j];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            occ    <= occ + push_cnt - pop_cnt;
        end
    end

    // A return at full credit means the scheduler over-returned; keep the count, flag it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < NUM_SCHEDULERS; s++) begin
                credit[s] <= CRD_W'(SCHED_CREDITS);
            end
            credit_err <= 1'b0;
        end else begin
            for (int s = 0; s < NUM_SCHEDULERS; s++) begin
                if (o_sched_uop_p[s] && !i_sched_credit_ret[s]) begin
                    credit[s] <= credit[s] - CRD_W'(1);
                end else if (!o_sched_uop_p[s] && i_sched_credit_ret[s]) begin
                    if (credit[s] == CRD_W'(SCHED_CREDITS)) begin
                        credit_err <= 1'b1;
                    end else begin
                        credit[s] <= credit[s] + CRD_W'(1);
                    end
                end
            end
        end
    end

    assign o_desp_src_num_avail = OCC_W'(BUFFER_LEN) - occ;
    assign o_credit_err         = credit_err;

`ifdef DESP_PERF_CNT_EN
    logic [31:0] perf_desp;
    logic [31:0] perf_stall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perf_desp  <= '0;
            perf_stall <= '0;
        end else begin
            perf_desp <= perf_desp + 32'(n_desp);
            if (win_v[0] && !i_flush && n_desp == '0) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end

    assign o_perf_desp_cnt  = perf_desp;
    assign o_perf_stall_cnt = perf_stall;
`else
    assign o_perf_desp_cnt  = '0;
    assign o_perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_uop_credit_despatcher.sv
// tb/tb_uop_credit_despatcher.sv - randomized and directed check of uop_credit_despatcher against a queue model
module tb_uop_credit_despatcher;
    import uop_credit_despatcher_pkg::*;

    localparam int IW = 3;
    localparam int OW = 2;
    localparam int BL = 8;
    localparam int NS = 4;
    localparam int SC = 8;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_flush = 1'b0;
    logic [IW-1:0]   i_desp_inp_p = '0;
    micro_op_t       i_desp_inp [IW];
    logic [3:0]      o_desp_src_num_avail;
    logic [NS-1:0]   o_sched_uop_p;
    micro_op_t       o_sched_inp [NS];
    logic [NS-1:0]   i_sched_credit_ret = '0;
    logic            o_credit_err;
    logic [31:0]     o_perf_desp_cnt;
    logic [31:0]     o_perf_stall_cnt;

    int tests = 0;
    int fails = 0;

    micro_op_t   mq[$];
    int          mcred [NS];
    bit          merr;
    logic [31:0] mdesp;
    logic [31:0] mstall;

    always #5 i_clk = ~i_clk;

    uop_credit_despatcher dut (
        .i_clk                (i_clk),
        .i_rst                (i_rst),
        .i_flush              (i_flush),
        .i_desp_inp_p         (i_desp_inp_p),
        .i_desp_inp           (i_desp_inp),
        .o_desp_src_num_avail (o_desp_src_num_avail),
        .o_sched_uop_p        (o_sched_uop_p),
        .o_sched_inp          (o_sched_inp),
        .i_sched_credit_ret   (i_sched_credit_ret),
        .o_credit_err         (o_credit_err),
        .o_perf_desp_cnt      (o_perf_desp_cnt),
        .o_perf_stall_cnt     (o_perf_stall_cnt)
    );

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic micro_op_t mk(input int eu, input int pl);
        micro_op_t u;
        u.exec_unit = EU_W'(eu);
        u.payload   = 16'(pl);
        return u;
    endfunction

    function automatic micro_op_t rnd_uop();
        int r;
        r = $urandom_range(0, 24);
        if (r == 0) return mk(4 + $urandom_range(0, 3), $urandom);
        return mk(r % NS, $urandom);
    endfunction

    function automatic void model_reset();
        mq.delete();
        for (int s = 0; s < NS; s++) mcred[s] = SC;
        merr   = 1'b0;
        mdesp  = '0;
        mstall = '0;
    endfunction

    // One clock: drive, predict from the queue model, compare, then advance the model.
    task automatic step(input int n, input micro_op_t u0, input micro_op_t u1, input micro_op_t u2,
                        input logic fl, input logic [NS-1:0] ret);
        micro_op_t     uin [IW];
        micro_op_t     ei [NS];
        logic [NS-1:0] ep;
        logic [NS-1:0] used;
        int            nd;
        int            qsz;
        int            junk;
        uin[0] = u0;
        uin[1] = u1;
        uin[2] = u2;
        @(posedge i_clk);
        #1;
        junk = int'($urandom_range(0, 7)) & ~((1 << (n + 1)) - 1);
        i_flush            = fl;
        i_desp_inp_p       = IW'(((1 << n) - 1) | junk);
        for (int i = 0; i < IW; i++) i_desp_inp[i] = uin[i];
        i_sched_credit_ret = ret;

        ep   = '0;
        used = '0;
        nd   = 0;
        qsz  = mq.size();
        for (int s = 0; s < NS; s++) ei[s] = '0;
        if (!fl) begin
            for (int k = 0; k < OW; k++) begin
                micro_op_t u;
                int        eu;
                if (k >= qsz + n) break;
                u  = (k < qsz) ? mq[k] : uin[k - qsz];
                eu = int'(u.exec_unit);
                if (eu >= NS) break;
                if (mcred[eu] == 0 || used[eu]) break;
                used[eu] = 1'b1;
                ep[eu]   = 1'b1;
                ei[eu]   = u;
                nd++;
            end
        end

        #2;
        lit("avail", 32'(o_desp_src_num_avail), 32'(BL - qsz));
        lit("uop_p", 32'(o_sched_uop_p), 32'(ep));
        for (int s = 0; s < NS; s++) begin
            if (ep[s]) lit($sformatf("sched_inp%0d", s), 32'(o_sched_inp[s]), 32'(ei[s]));
        end
        lit("credit_err", 32'(o_credit_err), 32'(merr));
`ifdef DESP_PERF_CNT_EN
        lit("perf_desp", o_perf_desp_cnt, mdesp);
        lit("perf_stall", o_perf_stall_cnt, mstall);
`else
        lit("perf_desp", o_perf_desp_cnt, 32'd0);
        lit("perf_stall", o_perf_stall_cnt, 32'd0);
`endif

        if (qsz + n > 0 && !fl && nd == 0) mstall = mstall + 32'd1;
        mdesp = mdesp + 32'(nd);
        if (fl) begin
            mq.delete();
        end else begin
            int pop;
            int byp;
            pop = (nd < qsz) ? nd : qsz;
            byp = nd - pop;
            repeat (pop) void'(mq.pop_front());
            for (int i = byp; i < n; i++) mq.push_back(uin[i]);
        end
        for (int s = 0; s < NS; s++) begin
            if (ep[s] && !ret[s]) mcred[s]--;
            else if (!ep[s] && ret[s]) begin
                if (mcred[s] == SC) merr = 1'b1;
                else mcred[s]++;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        i_rst              = 1'b1;
        i_flush            = 1'b0;
        i_sched_credit_ret = '0;
        i_desp_inp_p       = 3'b011;
        i_desp_inp[0]      = mk(0, 16'h11);
        i_desp_inp[1]      = mk(1, 16'h22);
        @(posedge i_clk);
        #3;
        lit("rst_uop_p", 32'(o_sched_uop_p), 32'd0);
        for (int s = 0; s < NS; s++) lit("rst_sched_inp", 32'(o_sched_inp[s]), 32'd0);
        lit("rst_avail", 32'(o_desp_src_num_avail), 32'(BL));
        lit("rst_err", 32'(o_credit_err), 32'd0);
        lit("rst_perf_desp", o_perf_desp_cnt, 32'd0);
        lit("rst_perf_stall", o_perf_stall_cnt, 32'd0);
        i_rst        = 1'b0;
        i_desp_inp_p = '0;
        model_reset();
    endtask

    initial begin
        micro_op_t a;
        micro_op_t b;
        micro_op_t c;
        micro_op_t z;
        z = '0;
        for (int i = 0; i < IW; i++) i_desp_inp[i] = '0;
        model_reset();
        do_reset();

        // Bypass of two uops to distinct schedulers in the same cycle
        a = mk(0, 16'hA0);
        b = mk(1, 16'hB1);
        step(2, a, b, z, 1'b0, '0);
        lit("t1_p", 32'(o_sched_uop_p), 32'b0011);
        lit("t1_inp0", 32'(o_sched_inp[0]), 32'(a));
        lit("t1_inp1", 32'(o_sched_inp[1]), 32'(b));
        lit("t1_avail", 32'(o_desp_src_num_avail), 32'd8);
        step(0, z, z, z, 1'b0, '0);
        lit("t1_avail_next", 32'(o_desp_src_num_avail), 32'd8);

        // Three uops to one scheduler drain one per cycle
        a = mk(2, 16'h200);
        b = mk(2, 16'h201);
        c = mk(2, 16'h202);
        step(3, a, b, c, 1'b0, '0);
        lit("t2_p_a", 32'(o_sched_uop_p), 32'b0100);
        lit("t2_inp_a", 32'(o_sched_inp[2]), 32'(a));
        lit("t2_avail_a", 32'(o_desp_src_num_avail), 32'd8);
        step(0, z, z, z, 1'b0, '0);
        lit("t2_inp_b", 32'(o_sched_inp[2]), 32'(b));
        lit("t2_avail_b", 32'(o_desp_src_num_avail), 32'd6);
        step(0, z, z, z, 1'b0, '0);
        lit("t2_inp_c", 32'(o_sched_inp[2]), 32'(c));
        lit("t2_avail_c", 32'(o_desp_src_num_avail), 32'd7);
        step(0, z, z, z, 1'b0, '0);
        lit("t2_p_d", 32'(o_sched_uop_p), 32'd0);
        lit("t2_avail_d", 32'(o_desp_src_num_avail), 32'd8);

        // Exhaust scheduler 3 credits, then a returned credit is usable next cycle
        for (int i = 0; i < SC; i++) begin
            step(1, mk(3, i), z, z, 1'b0, '0);
            lit("t3_drain_p", 32'(o_sched_uop_p), 32'b1000);
        end
        step(1, mk(3, 16'h99), z, z, 1'b0, '0);
        lit("t3_stall_p", 32'(o_sched_uop_p), 32'd0);
        step(0, z, z, z, 1'b0, 4'b1000);
        lit("t3_ret_p", 32'(o_sched_uop_p), 32'd0);
        step(0, z, z, z, 1'b0, '0);
        lit("t3_resume_p", 32'(o_sched_uop_p), 32'b1000);
        lit("t3_resume_inp", 32'(o_sched_inp[3]), 32'(mk(3, 16'h99)));
`ifdef DESP_PERF_CNT_EN
        lit("t3_stall_cnt", o_perf_stall_cnt, 32'd2);
        lit("t3_desp_cnt", o_perf_desp_cnt, 32'd13);
`else
        lit("t3_stall_cnt", o_perf_stall_cnt, 32'd0);
        lit("t3_desp_cnt", o_perf_desp_cnt, 32'd0);
`endif

        // Blocked slot 0 holds back a younger uop to a free scheduler
        step(2, mk(3, 16'h300), mk(0, 16'h301), z, 1'b0, '0);
        lit("t4_p", 32'(o_sched_uop_p), 32'd0);

        // Fill to full, then flush with inputs present
        step(3, mk(1, 1), mk(1, 2), mk(1, 3), 1'b0, '0);
        lit("t5_p_fill1", 32'(o_sched_uop_p), 32'd0);
        step(3, mk(1, 4), mk(1, 5), mk(1, 6), 1'b0, '0);
        lit("t5_p_fill2", 32'(o_sched_uop_p), 32'd0);
        step(0, z, z, z, 1'b0, '0);
        lit("t5_avail_full", 32'(o_desp_src_num_avail), 32'd0);
        step(2, mk(0, 7), mk(1, 8), z, 1'b1, '0);
        lit("t5_flush_p", 32'(o_sched_uop_p), 32'd0);
        a = mk(1, 16'h1F);
        step(1, a, z, z, 1'b0, '0);
        lit("t5_avail_after", 32'(o_desp_src_num_avail), 32'd8);
        lit("t5_p_after", 32'(o_sched_uop_p), 32'b0010);
        lit("t5_inp_after", 32'(o_sched_inp[1]), 32'(a));

        // Randomized traffic with legal credit returns and occasional flushes
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int            room;
            int            n;
            logic [NS-1:0] ret;
            room = BL - mq.size();
            n    = $urandom_range(0, (room < IW) ? room : IW);
            for (int s = 0; s < NS; s++) ret[s] = (mcred[s] < SC) && ($urandom_range(0, 2) == 0);
            step(n, rnd_uop(), rnd_uop(), rnd_uop(), ($urandom_range(0, 24) == 0), ret);
        end

        // Over-return at full credit sets a sticky error cleared only by reset
        do_reset();
        step(0, z, z, z, 1'b0, 4'b0001);
        lit("t6_err_before", 32'(o_credit_err), 32'd0);
        step(0, z, z, z, 1'b0, '0);
        lit("t6_err_set", 32'(o_credit_err), 32'd1);
        step(1, mk(0, 5), z, z, 1'b1, '0);
        lit("t6_err_hold", 32'(o_credit_err), 32'd1);
        do_reset();
        step(0, z, z, z, 1'b0, '0);
        lit("t6_err_clear", 32'(o_credit_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
